// File: rtl/memory_8x8_if.sv
// Bit-level access bus for the 8x8 scratch store: select/op, address, write and read data.
interface memory_8x8_if;
    logic select;
    logic op;
    logic adr0, adr1, adr2;
    logic i0, i1, i2, i3, i4, i5, i6, i7;
    logic o0, o1, o2, o3, o4, o5, o6, o7;

    modport master (
        output select, op, adr0, adr1, adr2,
        output i0, i1, i2, i3, i4, i5, i6, i7,
        input  o0, o1, o2, o3, o4, o5, o6, o7
    );

    modport slave (
        input  select, op, adr0, adr1, adr2,
        input  i0, i1, i2, i3, i4, i5, i6, i7,
        output o0, o1, o2, o3, o4, o5, o6, o7
    );
endinterface

// File: rtl/memory_8x8.sv
// Eight-word by eight-bit synchronous store with chip select and a registered read port.
// Optional MEMORY_8X8_WRITE_THROUGH_EN: a write also updates the read register with the written word.
module memory_8x8 (
    input  logic          clk,
    input  logic          rst_n,
    memory_8x8_if.slave   bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_d;

    // adr0 and i0 are the most significant bits
    assign w_addr = {bus.adr0, bus.adr1, bus.adr2};
    assign w_d    = {bus.i0, bus.i1, bus.i2, bus.i3, bus.i4, bus.i5, bus.i6, bus.i7};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem[ADDR_W'(k)] <= '0;
            end
            r_q <= '0;
        end else if (bus.select) begin
            if (bus.op) begin
                r_mem[w_addr] <= w_d;
`ifdef MEMORY_8X8_WRITE_THROUGH_EN
                r_q <= w_d;
`else
                r_q <= r_q;
`endif
            end else begin
                r_q <= r_mem[w_addr];
            end
        end
    end

    assign bus.o0 = r_q[7];
    assign bus.o1 = r_q[6];
    assign bus.o2 = r_q[5];
    assign bus.o3 = r_q[4];
    assign bus.o4 = r_q[3];
    assign bus.o5 = r_q[2];
    assign bus.o6 = r_q[1];
    assign bus.o7 = r_q[0];
endmodule

// File: tb/tb_memory_8x8.sv
// Self-checking bench for memory_8x8: directed test-plan steps plus random traffic against a word-array model.
module tb_memory_8x8;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    memory_8x8_if bus ();

    memory_8x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain array of words plus the last value shown on the read port
    logic [7:0] m_mem [8];
    logic [7:0] m_q;

    function automatic logic [7:0] dut_q();
        return {bus.o0, bus.o1, bus.o2, bus.o3, bus.o4, bus.o5, bus.o6, bus.o7};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: drive on falling edge, advance model on rising edge, compare 1 time unit later
    task automatic step(input bit rst, input bit sel, input bit wr,
                        input logic [2:0] a, input logic [7:0] d, input string tag);
        @(negedge clk);
        rst_n = ~rst;
        bus.select = sel;
        bus.op = wr;
        {bus.adr0, bus.adr1, bus.adr2} = a;
        {bus.i0, bus.i1, bus.i2, bus.i3, bus.i4, bus.i5, bus.i6, bus.i7} = d;
        @(posedge clk);
        if (rst) begin
            foreach (m_mem[k]) m_mem[k] = 8'h00;
            m_q = 8'h00;
        end else if (sel) begin
            if (wr) begin
                m_mem[a] = d;
`ifdef MEMORY_8X8_WRITE_THROUGH_EN
                m_q = d;
`endif
            end else begin
                m_q = m_mem[a];
            end
        end
        #1;
        chk(tag, dut_q(), m_q);
    endtask

    logic [7:0] word_str [8];
    logic [7:0] q_before;

    initial begin
        word_str = '{8'h65, 8'h6E, 8'h67, 8'h69, 8'h6E, 8'h65, 8'h65, 8'h72};
        foreach (m_mem[k]) m_mem[k] = 8'h00;
        m_q = 8'h00;
        rst_n = 1'b0;
        bus.select = 1'b0;
        bus.op = 1'b0;
        {bus.adr0, bus.adr1, bus.adr2} = 3'd0;
        {bus.i0, bus.i1, bus.i2, bus.i3, bus.i4, bus.i5, bus.i6, bus.i7} = 8'h00;

        // Reset for two edges, then every word reads zero
        step(1'b1, 1'b1, 1'b1, 3'd3, 8'hFF, "rst0");
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, "rst1");
        chk("rst_q", dut_q(), 8'h00);
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b1, 1'b0, 3'(a), 8'h00, "rst_read");
            chk("rst_read_const", dut_q(), 8'h00);
        end

        // String fill, then read back
        for (int a = 0; a < 8; a++) step(1'b0, 1'b1, 1'b1, 3'(a), word_str[a], "fill");
        chk("fill_q_hold", dut_q(),
`ifdef MEMORY_8X8_WRITE_THROUGH_EN
            8'h72
`else
            8'h00
`endif
        );
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b1, 1'b0, 3'(a), 8'h00, "str_read");
            chk("str_read_const", dut_q(), word_str[a]);
        end

        // Bit ordering: i0 is bit 7, adr0 is address MSB
        step(1'b0, 1'b1, 1'b1, 3'b100, 8'h80, "bit_wr");
        step(1'b0, 1'b1, 1'b0, 3'b100, 8'h00, "bit_rd4");
        chk("bit_rd4_const", dut_q(), 8'h80);
        chk("bit_o0", {7'd0, bus.o0}, 8'h01);
        step(1'b0, 1'b1, 1'b0, 3'b001, 8'h00, "bit_rd1");
        chk("bit_rd1_const", dut_q(), 8'h6E);

        // Select gating: deselected write has no effect
        q_before = dut_q();
        step(1'b0, 1'b0, 1'b1, 3'd2, 8'hFF, "idle_wr");
        chk("idle_hold", dut_q(), q_before);
        step(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, "idle_rd2");
        chk("idle_rd2_const", dut_q(), 8'h67);

        // Overwrite and read-after-write
        step(1'b0, 1'b1, 1'b1, 3'd7, 8'hA5, "ow_wr");
`ifdef MEMORY_8X8_WRITE_THROUGH_EN
        chk("ow_wt_const", dut_q(), 8'hA5);
`else
        chk("ow_hold_const", dut_q(), 8'h67);
`endif
        step(1'b0, 1'b1, 1'b0, 3'd7, 8'h00, "ow_rd");
        chk("ow_rd_const", dut_q(), 8'hA5);

        // Mid-sweep reset with a write on the same edge
        step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, "mid_rd0");
        step(1'b1, 1'b1, 1'b1, 3'd1, 8'h5A, "mid_rst");
        chk("mid_rst_const", dut_q(), 8'h00);
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b1, 1'b0, 3'(a), 8'h00, "mid_read");
            chk("mid_read_const", dut_q(), 8'h00);
        end

        // Random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom),
                 3'($urandom), 8'($urandom), "rand");
        end
        for (int a = 0; a < 8; a++) step(1'b0, 1'b1, 1'b0, 3'(a), 8'h00, "final_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
